// File: rtl/flag_unit_if.sv
// Branch-condition interface between the ALU/issue side and the flag unit.
// master: ALU/issue side driving results and control strobes.
// slave : flag unit returning live flags, busy and error status.
interface flag_unit_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              alu_valid;
  logic              flag_we;
  logic              op_start;
  logic              flag_save;
  logic              flag_restore;
  logic              signBit;
  logic              zeroBit;
  logic              carryBit;
  logic              flags_busy;
  logic              flag_err;

  modport master (
    output alu_result, alu_carry, alu_valid, flag_we, op_start,
           flag_save, flag_restore,
    input  signBit, zeroBit, carryBit, flags_busy, flag_err
  );

  modport slave (
    input  alu_result, alu_carry, alu_valid, flag_we, op_start,
           flag_save, flag_restore,
    output signBit, zeroBit, carryBit, flags_busy, flag_err
  );
endinterface

// File: rtl/flag_unit.sv
// flag_unit: architectural sign/zero/carry flags with a one-level shadow
// copy and a busy indication while a multi-cycle flag-setting op is pending.
// Optional feature macro FLAG_BYPASS_EN: forwards freshly computed flags to
// the outputs in the capture cycle and drops flags_busy as soon as the
// pending result arrives. Without it, outputs come from registers only and
// flags_busy also covers every capture cycle.
module flag_unit #(
  parameter int DATA_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  flag_unit_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t     state_r;
  logic       err_r;
  logic [2:0] live_r;       // {sign, zero, carry}
  logic [2:0] shadow_r;     // {sign, zero, carry}
  logic [2:0] new_flags_s;
  logic       capture_s;

  // Flags derived from an ALU result: {sign, zero, carry}.
  function automatic logic [2:0] compute_flags(input logic [DATA_W-1:0] res,
                                               input logic              carry);
    compute_flags = {res[DATA_W-1], (res == {DATA_W{1'b0}}), carry};
  endfunction

  // Decide whether this cycle writes the live flags from the ALU.
  always_comb begin
    new_flags_s = compute_flags(bus.alu_result, bus.alu_carry);
    capture_s   = 1'b0;
    case (state_r)
      IDLE:    capture_s = bus.alu_valid & bus.flag_we;
      PENDING: capture_s = bus.alu_valid;   // pending op always sets flags
      default: capture_s = 1'b0;
    endcase
  end

  // Control FSM: tracks an outstanding multi-cycle op and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.op_start) begin
            state_r <= PENDING;
          end else begin
            state_r <= IDLE;
          end
        end
        PENDING: begin
          // A second launch is a protocol error; the original op is kept.
          if (bus.op_start) begin
            err_r <= 1'b1;
          end else begin
            err_r <= err_r;
          end
          if (bus.alu_valid) begin
            state_r <= IDLE;
          end else begin
            state_r <= PENDING;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Live and shadow flag registers; capture takes priority over restore,
  // and save always samples the pre-edge live value (so save+restore swaps).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_r   <= 3'b000;
      shadow_r <= 3'b000;
    end else begin
      if (capture_s) begin
        live_r <= new_flags_s;
      end else if (bus.flag_restore) begin
        live_r <= shadow_r;
      end else begin
        live_r <= live_r;
      end
      if (bus.flag_save) begin
        shadow_r <= live_r;
      end else begin
        shadow_r <= shadow_r;
      end
    end
  end

  // Output drive: flags, busy and error toward jump control.
  always_comb begin
    bus.flag_err = err_r;
`ifdef FLAG_BYPASS_EN
    if (capture_s) begin
      {bus.signBit, bus.zeroBit, bus.carryBit} = new_flags_s;
    end else begin
      {bus.signBit, bus.zeroBit, bus.carryBit} = live_r;
    end
    bus.flags_busy = (state_r == PENDING) & ~bus.alu_valid;
`else
    {bus.signBit, bus.zeroBit, bus.carryBit} = live_r;
    // Flags written this cycle are not visible until the next one.
    bus.flags_busy = (state_r == PENDING) | capture_s;
`endif
  end

endmodule

// File: tb/tb_flag_unit.sv
// Self-checking bench for flag_unit: a driver applies one directed vector per
// cycle and queues the hand-computed expected outputs for that cycle; a
// monitor pops and compares on every falling edge.
module tb_flag_unit;

`ifdef FLAG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic NB = ~BYP;   // busy in a capture cycle without bypass

  typedef struct packed {
    logic [31:0] id;
    logic [4:0]  e;             // {sign, zero, carry, busy, err}
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   step_id;
  exp_t sb[$];

  flag_unit_if #(.DATA_W(32)) bus ();

  flag_unit #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Visible flags in a capture cycle: new values with bypass, old otherwise.
  function automatic logic [2:0] sel(input logic [2:0] nf, input logic [2:0] of);
    sel = BYP ? nf : of;
  endfunction

  task automatic step(input logic r, input logic [31:0] res, input logic c,
                      input logic v, input logic we, input logic st,
                      input logic sv, input logic rs,
                      input logic [2:0] ef, input logic eb, input logic ee);
    exp_t x;
    @(posedge clk);
    #1;
    rst                  = r;
    bus.alu_result       = res;
    bus.alu_carry        = c;
    bus.alu_valid        = v;
    bus.flag_we          = we;
    bus.op_start         = st;
    bus.flag_save        = sv;
    bus.flag_restore     = rs;
    x.id                 = step_id;
    x.e                  = {ef, eb, ee};
    sb.push_back(x);
    step_id++;
  endtask

  task automatic idle(input logic [2:0] ef, input logic eb, input logic ee);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ef, eb, ee);
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t x;
    logic [4:0] got;
    if (sb.size() > 0) begin
      x   = sb.pop_front();
      got = {bus.signBit, bus.zeroBit, bus.carryBit, bus.flags_busy, bus.flag_err};
      checks++;
      if (got !== x.e) begin
        errors++;
        $display("FAIL step%0d {s,z,c,busy,err}: got %b expected %b", x.id, got, x.e);
      end
    end
  end

  initial begin
    checks  = 0;
    errors  = 0;
    step_id = 0;
    rst     = 1'b1;
    bus.alu_result   = 32'h0;
    bus.alu_carry    = 1'b0;
    bus.alu_valid    = 1'b0;
    bus.flag_we      = 1'b0;
    bus.op_start     = 1'b0;
    bus.flag_save    = 1'b0;
    bus.flag_restore = 1'b0;

    // reset state
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    idle(3'b000, 1'b0, 1'b0);
    // IDLE capture of 0x80000000, carry 1 -> {1,0,1}
    step(1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, sel(3'b101, 3'b000), NB, 1'b0);
    idle(3'b101, 1'b0, 1'b0);
    // flag_we=0 in IDLE: no change
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b101, 1'b0, 1'b0);
    idle(3'b101, 1'b0, 1'b0);
    // flag_we=1 with zero result -> {0,1,0}
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, sel(3'b010, 3'b101), NB, 1'b0);
    idle(3'b010, 1'b0, 1'b0);
    // multi-cycle op: launch, 3 waiting cycles, result 5 with flag_we=0
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0);
    idle(3'b010, 1'b1, 1'b0);
    idle(3'b010, 1'b1, 1'b0);
    idle(3'b010, 1'b1, 1'b0);
    step(1'b0, 32'h5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, sel(3'b000, 3'b010), NB, 1'b0);
    idle(3'b000, 1'b0, 1'b0);
    // save/restore: live {1,0,1}, save, set {0,1,0}, restore -> {1,0,1}
    step(1'b0, 32'h8000_0001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, sel(3'b101, 3'b000), NB, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b101, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, sel(3'b010, 3'b101), NB, 1'b0);
    idle(3'b010, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0);
    idle(3'b101, 1'b0, 1'b0);
    // swap: live {0,1,0}, shadow {1,0,1} -> live {1,0,1}, shadow {0,1,0}
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, sel(3'b010, 3'b101), NB, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b010, 1'b0, 1'b0);
    idle(3'b101, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b101, 1'b0, 1'b0);
    idle(3'b010, 1'b0, 1'b0);
    // capture beats restore; save still takes pre-edge live {0,1,0}
    step(1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, sel(3'b101, 3'b010), NB, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b101, 1'b0, 1'b0);
    idle(3'b010, 1'b0, 1'b0);
    // protocol error: op_start while pending, sticky after completion
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 1'b1);
    step(1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, sel(3'b100, 3'b010), NB, 1'b1);
    idle(3'b100, 1'b0, 1'b1);
    idle(3'b100, 1'b0, 1'b1);
    // reset mid-PENDING: immediate clear, late alu_valid ignored
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 1'b0, 1'b1);
    idle(3'b100, 1'b1, 1'b1);
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    step(1'b0, 32'h8000_0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    idle(3'b000, 1'b0, 1'b0);
    // capture and op_start together in IDLE, then pending completion
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, sel(3'b011, 3'b000), NB, 1'b0);
    idle(3'b011, 1'b1, 1'b0);
    step(1'b0, 32'h7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, sel(3'b000, 3'b011), NB, 1'b0);
    idle(3'b000, 1'b0, 1'b0);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(posedge clk);
    end
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
